// File: rtl/frame_sequencer.sv
// frame_sequencer: per-frame scheduler for the VGA scope path.
// Each frame runs the clear engine, then every enabled draw engine in ascending
// channel order, then a fixed hold interval. Frames repeat while enable is high.
// The active engine's pixel-write stream is muxed onto one registered write port.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   enable              run frames while high (checked in IDLE and at HOLD exit)
//   ch_en[NUM_CH]       per-channel draw enable, latched at frame start
//   clr_start/clr_done  clear engine start pulse / finished
//   clr_x/y/color/we    clear engine pixel stream
//   draw_start/done     per-channel start pulse (one-hot) / finished
//   draw_x/y/color/we   packed draw engine pixel streams, channel i at [i*W +: W]
//   pix_x/y/color/we    registered frame-buffer write port
//   busy                high in any state except IDLE
//   frame_cnt           completed-frame counter (wraps)
//   err                 sticky timeout flag
//
// Optional feature: define FRAME_SEQ_TIMEOUT_EN to add a per-phase timeout
// (parameter TIMEOUT) in CLEAR and DRAW. Without it err is tied to 0.
module frame_sequencer #(
  parameter int unsigned COORD_W     = 8,
  parameter int unsigned COLOR_W     = 12,
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned HOLD_CYCLES = 10000,
  parameter int unsigned HOLD_W      = 16
`ifdef FRAME_SEQ_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT     = 65535
`endif
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        enable,
  input  logic [NUM_CH-1:0]           ch_en,
  output logic                        clr_start,
  input  logic                        clr_done,
  input  logic [COORD_W-1:0]          clr_x,
  input  logic [COORD_W-1:0]          clr_y,
  input  logic [COLOR_W-1:0]          clr_color,
  input  logic                        clr_we,
  output logic [NUM_CH-1:0]           draw_start,
  input  logic [NUM_CH-1:0]           draw_done,
  input  logic [NUM_CH*COORD_W-1:0]   draw_x,
  input  logic [NUM_CH*COORD_W-1:0]   draw_y,
  input  logic [NUM_CH*COLOR_W-1:0]   draw_color,
  input  logic [NUM_CH-1:0]           draw_we,
  output logic [COORD_W-1:0]          pix_x,
  output logic [COORD_W-1:0]          pix_y,
  output logic [COLOR_W-1:0]          pix_color,
  output logic                        pix_we,
  output logic                        busy,
  output logic [15:0]                 frame_cnt,
  output logic                        err
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  // HOLD_CYCLES=0 degenerates to a single hold cycle.
  localparam logic [HOLD_W-1:0] HOLD_LAST =
      (HOLD_CYCLES == 0) ? '0 : HOLD_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StClear, StDraw, StHold} state_e;

  state_e              state_q, state_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [NUM_CH-1:0]   mask_q, mask_d;
  logic                first_q, first_d;   // first cycle of a state or channel
  logic [HOLD_W-1:0]   hold_q, hold_d;
  logic [15:0]         frame_q, frame_d;
  logic [COORD_W-1:0]  pix_x_q, pix_x_d, pix_y_q, pix_y_d;
  logic [COLOR_W-1:0]  pix_color_q, pix_color_d;
  logic                pix_we_q, pix_we_d;

  logic [CH_W-1:0]     first_ch, next_ch;
  logic                next_found;
  logic                cur_draw_done, sel_we;
  logic [COORD_W-1:0]  sel_x, sel_y;
  logic [COLOR_W-1:0]  sel_color;
  logic                phase_done;

  // Channel search and current-channel selection.
  always_comb begin
    first_ch      = '0;
    next_ch       = '0;
    next_found    = 1'b0;
    cur_draw_done = 1'b0;
    sel_x         = '0;
    sel_y         = '0;
    sel_color     = '0;
    sel_we        = 1'b0;
    draw_start    = '0;
    // Descending scan so the lowest qualifying bit wins.
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (mask_q[i]) begin
        first_ch = CH_W'(i);
        if (CH_W'(i) > ch_q) begin
          next_ch    = CH_W'(i);
          next_found = 1'b1;
        end
      end
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (CH_W'(i) == ch_q) begin
        cur_draw_done = draw_done[i];
        sel_x         = draw_x[i*COORD_W +: COORD_W];
        sel_y         = draw_y[i*COORD_W +: COORD_W];
        sel_color     = draw_color[i*COLOR_W +: COLOR_W];
        sel_we        = draw_we[i];
        draw_start[i] = (state_q == StDraw) && first_q;
      end
    end
  end

  assign clr_start = (state_q == StClear) && first_q;
  assign busy      = (state_q != StIdle);

`ifdef FRAME_SEQ_TIMEOUT_EN
  logic [31:0] phase_q, phase_d;
  logic        err_q, err_d;
  logic        real_done, timeout_hit;

  always_comb begin
    real_done = 1'b0;
    if (!first_q) begin
      if (state_q == StClear)     real_done = clr_done;
      else if (state_q == StDraw) real_done = cur_draw_done;
    end
    timeout_hit = ((state_q == StClear) || (state_q == StDraw)) &&
                  ((phase_q + 32'd1) >= 32'(TIMEOUT));
    phase_done  = real_done || timeout_hit;
    err_d       = err_q || (timeout_hit && !real_done);
    phase_d     = first_d ? '0 : phase_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      phase_q <= '0;
      err_q   <= 1'b0;
    end else begin
      phase_q <= phase_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;
`else
  always_comb begin
    phase_done = 1'b0;
    if (!first_q) begin
      if (state_q == StClear)     phase_done = clr_done;
      else if (state_q == StDraw) phase_done = cur_draw_done;
    end
  end

  assign err = 1'b0;
`endif

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    mask_d  = mask_q;
    first_d = 1'b0;
    hold_d  = hold_q;
    frame_d = frame_q;
    case (state_q)
      StIdle: begin
        if (enable) begin
          mask_d  = ch_en;
          state_d = StClear;
          first_d = 1'b1;
        end
      end
      StClear: begin
        if (phase_done) begin
          first_d = 1'b1;
          if (|mask_q) begin
            state_d = StDraw;
            ch_d    = first_ch;
          end else begin
            state_d = StHold;
            hold_d  = '0;
          end
        end
      end
      StDraw: begin
        if (phase_done) begin
          first_d = 1'b1;
          if (next_found) begin
            ch_d = next_ch;
          end else begin
            state_d = StHold;
            hold_d  = '0;
          end
        end
      end
      StHold: begin
        hold_d = hold_q + 1'b1;
        if (hold_q == HOLD_LAST) begin
          frame_d = frame_q + 16'd1;
          if (enable) begin
            mask_d  = ch_en;
            state_d = StClear;
            first_d = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Pixel mux; the register delay means the first cycle after a state change
  // still carries the previous source's last write.
  always_comb begin
    pix_x_d     = '0;
    pix_y_d     = '0;
    pix_color_d = '0;
    pix_we_d    = 1'b0;
    if (state_q == StClear) begin
      pix_x_d     = clr_x;
      pix_y_d     = clr_y;
      pix_color_d = clr_color;
      pix_we_d    = clr_we;
    end else if (state_q == StDraw) begin
      pix_x_d     = sel_x;
      pix_y_d     = sel_y;
      pix_color_d = sel_color;
      pix_we_d    = sel_we;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      ch_q        <= '0;
      mask_q      <= '0;
      first_q     <= 1'b0;
      hold_q      <= '0;
      frame_q     <= '0;
      pix_x_q     <= '0;
      pix_y_q     <= '0;
      pix_color_q <= '0;
      pix_we_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      ch_q        <= ch_d;
      mask_q      <= mask_d;
      first_q     <= first_d;
      hold_q      <= hold_d;
      frame_q     <= frame_d;
      pix_x_q     <= pix_x_d;
      pix_y_q     <= pix_y_d;
      pix_color_q <= pix_color_d;
      pix_we_q    <= pix_we_d;
    end
  end

  assign pix_x     = pix_x_q;
  assign pix_y     = pix_y_q;
  assign pix_color = pix_color_q;
  assign pix_we    = pix_we_q;
  assign frame_cnt = frame_q;

endmodule

// File: tb/tb_frame_sequencer.sv
// Randomized bench for frame_sequencer. A reference model holds each frame as a
// list of phases (clear, enabled channels ascending, hold) and tracks position
// and age within the current phase; DUT outputs are compared every cycle.
module tb_frame_sequencer;

  localparam int COORD_W     = 8;
  localparam int COLOR_W     = 12;
  localparam int NUM_CH      = 2;
  localparam int HOLD_CYCLES = 4;
  localparam int HOLD_W      = 16;
  localparam int N_CYCLES    = 6000;

  localparam int PH_CLR  = -1;
  localparam int PH_HOLD = -2;
  localparam int PH_IDLE = -3;

  logic                      clk;
  logic                      rst_n;
  logic                      enable;
  logic [NUM_CH-1:0]         ch_en;
  logic                      clr_start;
  logic                      clr_done;
  logic [COORD_W-1:0]        clr_x, clr_y;
  logic [COLOR_W-1:0]        clr_color;
  logic                      clr_we;
  logic [NUM_CH-1:0]         draw_start;
  logic [NUM_CH-1:0]         draw_done;
  logic [NUM_CH*COORD_W-1:0] draw_x, draw_y;
  logic [NUM_CH*COLOR_W-1:0] draw_color;
  logic [NUM_CH-1:0]         draw_we;
  logic [COORD_W-1:0]        pix_x, pix_y;
  logic [COLOR_W-1:0]        pix_color;
  logic                      pix_we;
  logic                      busy;
  logic [15:0]               frame_cnt;
  logic                      err;

  frame_sequencer #(
    .COORD_W    (COORD_W),
    .COLOR_W    (COLOR_W),
    .NUM_CH     (NUM_CH),
    .HOLD_CYCLES(HOLD_CYCLES),
    .HOLD_W     (HOLD_W)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .ch_en     (ch_en),
    .clr_start (clr_start),
    .clr_done  (clr_done),
    .clr_x     (clr_x),
    .clr_y     (clr_y),
    .clr_color (clr_color),
    .clr_we    (clr_we),
    .draw_start(draw_start),
    .draw_done (draw_done),
    .draw_x    (draw_x),
    .draw_y    (draw_y),
    .draw_color(draw_color),
    .draw_we   (draw_we),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_color (pix_color),
    .pix_we    (pix_we),
    .busy      (busy),
    .frame_cnt (frame_cnt),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model state.
  int          m_phases[$];
  int          m_idx;
  int          m_age;
  bit          m_idle;
  int unsigned m_frames;
  logic [COORD_W-1:0] exp_x, exp_y;
  logic [COLOR_W-1:0] exp_c;
  logic               exp_we;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      if (n_fail <= 25)
        $display("FAIL %s cycle=%0d got=0x%0h expected=0x%0h", tag, cyc, got, exp);
    end
  endtask

  function automatic int cur_phase();
    return m_idle ? PH_IDLE : m_phases[m_idx];
  endfunction

  task automatic build_frame(input logic [NUM_CH-1:0] en);
    m_phases.delete();
    m_phases.push_back(PH_CLR);
    for (int c = 0; c < NUM_CH; c++) if (en[c]) m_phases.push_back(c);
    m_phases.push_back(PH_HOLD);
    m_idx  = 0;
    m_age  = 0;
    m_idle = 1'b0;
  endtask

  // Models what the upcoming rising edge does with the inputs now driven.
  task automatic model_edge();
    int  cur;
    int  hold_len;
    bit  done;
    hold_len = (HOLD_CYCLES == 0) ? 1 : HOLD_CYCLES;
    if (!rst_n) begin
      m_idle   = 1'b1;
      m_frames = 0;
      exp_x = '0; exp_y = '0; exp_c = '0; exp_we = 1'b0;
    end else begin
      cur = cur_phase();
      if (cur == PH_CLR) begin
        exp_x = clr_x; exp_y = clr_y; exp_c = clr_color; exp_we = clr_we;
      end else if (cur >= 0) begin
        exp_x  = draw_x[cur*COORD_W +: COORD_W];
        exp_y  = draw_y[cur*COORD_W +: COORD_W];
        exp_c  = draw_color[cur*COLOR_W +: COLOR_W];
        exp_we = draw_we[cur];
      end else begin
        exp_x = '0; exp_y = '0; exp_c = '0; exp_we = 1'b0;
      end

      if (cur == PH_IDLE) begin
        if (enable) build_frame(ch_en);
      end else if (cur == PH_HOLD) begin
        if (m_age == hold_len - 1) begin
          m_frames = (m_frames + 1) % 65536;
          if (enable) build_frame(ch_en);
          else m_idle = 1'b1;
        end else begin
          m_age++;
        end
      end else begin
        done = (cur == PH_CLR) ? clr_done : draw_done[cur];
        if (m_age > 0 && done) begin
          m_idx++;
          m_age = 0;
        end else begin
          m_age++;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int          cur;
    logic [31:0] exp_ds;
    cur    = cur_phase();
    exp_ds = (cur >= 0 && m_age == 0) ? (32'd1 << cur) : 32'd0;
    check_eq("busy",       32'(busy),       32'(!m_idle));
    check_eq("clr_start",  32'(clr_start),  32'(cur == PH_CLR && m_age == 0));
    check_eq("draw_start", 32'(draw_start), exp_ds);
    check_eq("frame_cnt",  32'(frame_cnt),  m_frames);
    check_eq("pix_x",      32'(pix_x),      32'(exp_x));
    check_eq("pix_y",      32'(pix_y),      32'(exp_y));
    check_eq("pix_color",  32'(pix_color),  32'(exp_c));
    check_eq("pix_we",     32'(pix_we),     32'(exp_we));
    check_eq("err",        32'(err),        32'd0);
  endtask

  task automatic drive_random();
    rst_n = ($urandom_range(0, 399) != 0);
    if (enable) begin
      if ($urandom_range(0, 99) < 2) enable = 1'b0;
    end else begin
      if ($urandom_range(0, 99) < 10) enable = 1'b1;
    end
    ch_en     = NUM_CH'($urandom);
    clr_done  = ($urandom_range(0, 3) == 0);
    for (int c = 0; c < NUM_CH; c++) draw_done[c] = ($urandom_range(0, 2) == 0);
    clr_x      = COORD_W'($urandom);
    clr_y      = COORD_W'($urandom);
    clr_color  = COLOR_W'($urandom);
    clr_we     = 1'($urandom);
    draw_x     = (NUM_CH*COORD_W)'($urandom);
    draw_y     = (NUM_CH*COORD_W)'($urandom);
    draw_color = (NUM_CH*COLOR_W)'($urandom);
    draw_we    = NUM_CH'($urandom);
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b1; ch_en = '0;
    clr_done = 1'b0; clr_x = '0; clr_y = '0; clr_color = '0; clr_we = 1'b0;
    draw_done = '0; draw_x = '0; draw_y = '0; draw_color = '0; draw_we = '0;
    m_idle = 1'b1; m_frames = 0; m_idx = 0; m_age = 0;
    exp_x = '0; exp_y = '0; exp_c = '0; exp_we = 1'b0;
    model_edge();
    repeat (2) begin
      @(negedge clk);
      cyc++;
      check_outputs();
      model_edge();
    end
    for (int n = 0; n < N_CYCLES; n++) begin
      @(negedge clk);
      cyc++;
      check_outputs();
      drive_random();
      model_edge();
    end
    @(negedge clk);
    cyc++;
    check_outputs();
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
